// File: rtl/hs32_mem_arb_pkg.sv
// Shared definitions for the hs32 memory arbiter: FSM state encoding,
// default exec-run limit and the run-counter width helper.
package hs32_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_F = 2'd1,
        BUS_E = 2'd2
    } hs32_state_e;

    localparam int HS32_MAX_EXEC_RUN = 3;

    function automatic int run_cnt_width(input int max_run);
        return (max_run < 2) ? 1 : $clog2(max_run + 1);
    endfunction

endpackage

// File: rtl/hs32_mem_arb.sv
// Two-requester (fetch/exec) single-port memory arbiter, exec-priority.
// Optional fairness limit on consecutive exec grants: define HS32_FAIR_ARB_EN.
module hs32_mem_arb
    import hs32_mem_arb_pkg::*;
#(
    parameter int MAX_EXEC_RUN = HS32_MAX_EXEC_RUN
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        fetch_req,
    input  logic [31:0] fetch_addr,
    output logic        fetch_ack,
    output logic [31:0] fetch_dtr,
    input  logic        exec_req,
    input  logic        exec_rw,
    input  logic [31:0] exec_addr,
    input  logic [31:0] exec_dtw,
    output logic        exec_ack,
    output logic [31:0] exec_dtr,
    output logic        mem_valid,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_dtw,
    input  logic        mem_ready,
    input  logic [31:0] mem_dtr
);

    hs32_state_e r_state;
    hs32_state_e w_state_nxt;
    logic        w_grant_f;
    logic        w_grant_e;
    logic        w_done_f;
    logic        w_done_e;
    logic        w_fetch_turn;
    logic        r_discard;

`ifdef HS32_FAIR_ARB_EN
    localparam int RUN_W = run_cnt_width(MAX_EXEC_RUN);
    logic [RUN_W-1:0] r_run_cnt;

    // Fetch takes precedence once exec has used up its run while fetch waits
    assign w_fetch_turn = fetch_req && !flush && (r_run_cnt == RUN_W'(MAX_EXEC_RUN));

    // Consecutive exec grants made while fetch is waiting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run_cnt <= {RUN_W{1'b0}};
        end else if (w_grant_f || (r_state == IDLE && !fetch_req)) begin
            r_run_cnt <= {RUN_W{1'b0}};
        end else if (w_grant_e && (r_run_cnt != RUN_W'(MAX_EXEC_RUN))) begin
            r_run_cnt <= r_run_cnt + RUN_W'(1);
        end else begin
            r_run_cnt <= r_run_cnt;
        end
    end
`else
    logic w_unused_max_run;
    assign w_unused_max_run = (MAX_EXEC_RUN != 0);
    assign w_fetch_turn     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant decision and transaction completion
    always_comb begin
        w_state_nxt = r_state;
        w_grant_f   = 1'b0;
        w_grant_e   = 1'b0;
        w_done_f    = 1'b0;
        w_done_e    = 1'b0;
        case (r_state)
            IDLE: begin
                if (exec_req && !w_fetch_turn) begin
                    w_state_nxt = BUS_E;
                    w_grant_e   = 1'b1;
                end else if (fetch_req && !flush) begin
                    w_state_nxt = BUS_F;
                    w_grant_f   = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            BUS_F: begin
                if (mem_ready) begin
                    w_state_nxt = IDLE;
                    w_done_f    = 1'b1;
                end else begin
                    w_state_nxt = BUS_F;
                end
            end
            BUS_E: begin
                if (mem_ready) begin
                    w_state_nxt = IDLE;
                    w_done_e    = 1'b1;
                end else begin
                    w_state_nxt = BUS_E;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Bus request registers, requester acks/data and the fetch discard flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_valid <= 1'b0;
            mem_rw    <= 1'b0;
            mem_addr  <= 32'h0000_0000;
            mem_dtw   <= 32'h0000_0000;
            fetch_ack <= 1'b0;
            fetch_dtr <= 32'h0000_0000;
            exec_ack  <= 1'b0;
            exec_dtr  <= 32'h0000_0000;
            r_discard <= 1'b0;
        end else begin
            fetch_ack <= 1'b0;
            exec_ack  <= 1'b0;
            if (w_grant_e) begin
                mem_valid <= 1'b1;
                mem_rw    <= exec_rw;
                mem_addr  <= exec_addr;
                mem_dtw   <= exec_dtw;
            end else if (w_grant_f) begin
                mem_valid <= 1'b1;
                mem_rw    <= 1'b0;
                mem_addr  <= fetch_addr;
                mem_dtw   <= 32'h0000_0000;
            end else if (w_done_f || w_done_e) begin
                mem_valid <= 1'b0;
            end
            if (w_done_e) begin
                exec_ack <= 1'b1;
                exec_dtr <= mem_dtr;
            end
            // A flush seen on the completing cycle discards just like an earlier one
            if (w_done_f && !r_discard && !flush) begin
                fetch_ack <= 1'b1;
                fetch_dtr <= mem_dtr;
            end
            if (r_state == BUS_F && !w_done_f) begin
                r_discard <= r_discard | flush;
            end else begin
                r_discard <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hs32_mem_arb.sv
// Directed self-checking bench for hs32_mem_arb; the arbitration-order step
// follows whichever build (HS32_FAIR_ARB_EN defined or not) is compiled.
module tb_hs32_mem_arb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_dtr;
    logic        exec_req;
    logic        exec_rw;
    logic [31:0] exec_addr;
    logic [31:0] exec_dtw;
    logic        exec_ack;
    logic [31:0] exec_dtr;
    logic        mem_valid;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_dtw;
    logic        mem_ready;
    logic [31:0] mem_dtr;

    int checks   = 0;
    int failures = 0;

    hs32_mem_arb #(.MAX_EXEC_RUN(3)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush      (flush),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_ack  (fetch_ack),
        .fetch_dtr  (fetch_dtr),
        .exec_req   (exec_req),
        .exec_rw    (exec_rw),
        .exec_addr  (exec_addr),
        .exec_dtw   (exec_dtw),
        .exec_ack   (exec_ack),
        .exec_dtr   (exec_dtr),
        .mem_valid  (mem_valid),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_dtw    (mem_dtw),
        .mem_ready  (mem_ready),
        .mem_dtr    (mem_dtr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected grant sequence for 8 back-to-back grants with both requests held
    logic [7:0] exp_is_fetch;

    initial begin
`ifdef HS32_FAIR_ARB_EN
        exp_is_fetch = 8'b1000_1000;  // bit i = grant i: E,E,E,F,E,E,E,F
`else
        exp_is_fetch = 8'b0000_0000;
`endif
        reset_n = 1'b0; flush = 1'b0;
        fetch_req = 1'b0; fetch_addr = 32'h0;
        exec_req = 1'b0; exec_rw = 1'b0; exec_addr = 32'h0; exec_dtw = 32'h0;
        mem_ready = 1'b0; mem_dtr = 32'h0;
        tick(); tick();
        chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_acks", {30'd0, fetch_ack, exec_ack}, 32'd0);
        chk("rst_fetch_dtr", fetch_dtr, 32'h0);
        chk("rst_exec_dtr", exec_dtr, 32'h0);
        reset_n = 1'b1;
        tick();

        // Fetch-only read, memory answers after 3 cycles
        fetch_req = 1'b1; fetch_addr = 32'h0000_0100;
        tick();
        chk("f1_valid", {31'd0, mem_valid}, 32'd1);
        chk("f1_addr", mem_addr, 32'h0000_0100);
        chk("f1_rw_dtw", {31'd0, mem_rw} | mem_dtw, 32'd0);
        tick();
        chk("f1_hold_valid", {31'd0, mem_valid}, 32'd1);
        tick();
        chk("f1_hold_addr", mem_addr, 32'h0000_0100);
        mem_ready = 1'b1; mem_dtr = 32'hDEAD_BEEF;
        tick();
        chk("f1_ack", {31'd0, fetch_ack}, 32'd1);
        chk("f1_dtr", fetch_dtr, 32'hDEAD_BEEF);
        chk("f1_valid_drop", {31'd0, mem_valid}, 32'd0);
        fetch_req = 1'b0; mem_ready = 1'b0; mem_dtr = 32'h0;
        tick();
        chk("f1_ack_pulse", {31'd0, fetch_ack}, 32'd0);

        // Stray mem_ready in IDLE
        mem_ready = 1'b1; mem_dtr = 32'h7777_7777;
        tick();
        chk("idle_ready_acks", {30'd0, fetch_ack, exec_ack}, 32'd0);
        chk("idle_ready_valid", {31'd0, mem_valid}, 32'd0);
        chk("idle_ready_dtr", fetch_dtr, 32'hDEAD_BEEF);
        mem_ready = 1'b0;

        // Simultaneous requests: exec write first, fetch granted as exec acks
        fetch_req = 1'b1; fetch_addr = 32'h0000_0300;
        exec_req = 1'b1; exec_rw = 1'b1; exec_addr = 32'h0000_0200; exec_dtw = 32'h1234_5678;
        tick();
        chk("sim_e_valid", {31'd0, mem_valid}, 32'd1);
        chk("sim_e_rw", {31'd0, mem_rw}, 32'd1);
        chk("sim_e_addr", mem_addr, 32'h0000_0200);
        chk("sim_e_dtw", mem_dtw, 32'h1234_5678);
        mem_ready = 1'b1;
        tick();
        chk("sim_e_ack", {30'd0, fetch_ack, exec_ack}, 32'd1);
        chk("sim_e_valid_drop", {31'd0, mem_valid}, 32'd0);
        exec_req = 1'b0; mem_ready = 1'b0;
        tick();
        chk("sim_f_valid", {31'd0, mem_valid}, 32'd1);
        chk("sim_f_addr", mem_addr, 32'h0000_0300);
        chk("sim_f_rw_dtw", {31'd0, mem_rw} | mem_dtw, 32'd0);

        // Flush coincident with mem_ready on this fetch
        mem_ready = 1'b1; mem_dtr = 32'hCAFE_F00D; flush = 1'b1;
        tick();
        chk("fl_ack", {31'd0, fetch_ack}, 32'd0);
        chk("fl_dtr", fetch_dtr, 32'hDEAD_BEEF);
        chk("fl_valid_drop", {31'd0, mem_valid}, 32'd0);
        flush = 1'b0; mem_ready = 1'b0; fetch_addr = 32'h0000_0304;
        tick();
        chk("fl_regrant_valid", {31'd0, mem_valid}, 32'd1);
        chk("fl_regrant_addr", mem_addr, 32'h0000_0304);
        mem_ready = 1'b1; mem_dtr = 32'h1111_2222;
        tick();
        chk("fl_clear_ack", {31'd0, fetch_ack}, 32'd1);
        chk("fl_clear_dtr", fetch_dtr, 32'h1111_2222);
        fetch_addr = 32'h0000_0400; mem_ready = 1'b0;

        // Flush earlier in BUS_F is remembered until completion
        tick();
        chk("fm_valid", {31'd0, mem_valid}, 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0; mem_ready = 1'b1; mem_dtr = 32'h9999_9999;
        tick();
        chk("fm_ack", {31'd0, fetch_ack}, 32'd0);
        chk("fm_dtr", fetch_dtr, 32'h1111_2222);
        mem_ready = 1'b0; flush = 1'b1;

        // Flush in IDLE blocks the fetch grant
        tick();
        chk("fi_blocked", {31'd0, mem_valid}, 32'd0);
        flush = 1'b0;
        tick();
        chk("fi_granted", {31'd0, mem_valid}, 32'd1);
        mem_ready = 1'b1; mem_dtr = 32'h3333_4444;
        tick();
        chk("fi_ack", {31'd0, fetch_ack}, 32'd1);
        fetch_req = 1'b0; mem_ready = 1'b0;

        // Exec read is not affected by flush
        exec_req = 1'b1; exec_rw = 1'b0; exec_addr = 32'h0000_0500; flush = 1'b1;
        tick();
        chk("er_valid", {31'd0, mem_valid}, 32'd1);
        chk("er_rw", {31'd0, mem_rw}, 32'd0);
        chk("er_addr", mem_addr, 32'h0000_0500);
        mem_ready = 1'b1; mem_dtr = 32'h55AA_55AA;
        tick();
        chk("er_ack", {31'd0, exec_ack}, 32'd1);
        chk("er_dtr", exec_dtr, 32'h55AA_55AA);
        exec_req = 1'b0; mem_ready = 1'b0; flush = 1'b0;
        tick();

        // Reset while a transaction is on the bus
        fetch_req = 1'b1; fetch_addr = 32'h0000_0600;
        tick();
        chk("rm_valid_before", {31'd0, mem_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rm_valid_async", {31'd0, mem_valid}, 32'd0);
        chk("rm_addr_async", mem_addr, 32'h0);
        chk("rm_fdtr_async", fetch_dtr, 32'h0);
        fetch_req = 1'b0;
        tick();
        reset_n = 1'b1; mem_ready = 1'b1; mem_dtr = 32'hBAD0_BAD0;
        tick();
        chk("rm_no_ack", {30'd0, fetch_ack, exec_ack}, 32'd0);
        mem_ready = 1'b0;
        tick();
        chk("rm_no_ack2", {30'd0, fetch_ack, exec_ack}, 32'd0);
        chk("rm_idle", {31'd0, mem_valid}, 32'd0);

        // Both requests held: grant order depends on the fairness build
        fetch_req = 1'b1; fetch_addr = 32'h0000_0F00;
        exec_req = 1'b1; exec_rw = 1'b1; exec_addr = 32'h0000_0E00; exec_dtw = 32'h0;
        for (int g = 0; g < 8; g++) begin
            tick();
            chk($sformatf("run%0d_valid", g), {31'd0, mem_valid}, 32'd1);
            chk($sformatf("run%0d_addr", g), mem_addr,
                exp_is_fetch[g] ? 32'h0000_0F00 : 32'h0000_0E00);
            mem_ready = 1'b1;
            tick();
            chk($sformatf("run%0d_ack", g), {30'd0, fetch_ack, exec_ack},
                exp_is_fetch[g] ? 32'd2 : 32'd1);
            mem_ready = 1'b0;
        end
        fetch_req = 1'b0; exec_req = 1'b0;
        tick();
        chk("end_idle", {31'd0, mem_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
